// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the multi-chain shift-register config engine:
// FSM state encoding and chain slice packing helper.
package sr_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // LSB position of chain c inside a packed NCH*WIDTH bus.
  function automatic int unsigned chain_lsb(input int unsigned c, input int unsigned w);
    return c * w;
  endfunction

endpackage

// File: rtl/sr_tick_gen.sv
// Half-period tick generator: one-cycle pulse every 2**div cycles, with the
// divider exponent latched and the counter restarted on each accepted start.
module sr_tick_gen #(
  parameter int unsigned DIV_WIDTH = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);

  localparam int unsigned CW = 1 << DIV_WIDTH;

  logic [DIV_WIDTH-1:0] r_div;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_mask;

  assign w_mask = (CW'(1) << r_div) - CW'(1);
  assign o_tick = (r_cnt == w_mask);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_div <= i_div;
      r_cnt <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sr_multichain_ctrl.sv
// Shift-register config engine: writes/reads NCH parallel chip chains on a
// shared clk_sr/load_sr, captures readback and flags per-chain mismatches.
module sr_multichain_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = 170,
  parameter int unsigned NCH             = 2,
  parameter int unsigned DIV_WIDTH       = 6,
  parameter bit          SHIFT_DIRECTION = 1'b1,
  parameter int unsigned LOAD_CYCLES     = 2
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic [NCH-1:0]       data_in,
  output logic                 clk_sr,
  output logic [NCH-1:0]       data_out,
  output logic                 load_sr,
  output logic                 busy,
  output logic                 done,
  output logic [NCH*WIDTH-1:0] dout,
  output logic [NCH-1:0]       mismatch
);

  localparam int unsigned BCW = $clog2(WIDTH + 1);
  localparam int unsigned LCW = $clog2(LOAD_CYCLES + 1);

  logic [2:0]     r_state, w_state_nxt;
  logic [BCW-1:0] r_bit_cnt;
  logic [LCW-1:0] r_load_cnt;
  logic           r_mode, r_wrote_once;
  logic           r_clk_sr, r_load_sr, r_busy, r_done;
  logic           w_tick, w_accept, w_shift, w_last_bit, w_enter_done;

  sr_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .i_clk   (clk_in),
    .i_rst   (rst),
    .i_clear (w_accept),
    .i_div   (div),
    .o_tick  (w_tick)
  );

  assign w_accept     = (r_state == ST_IDLE) && start;
  assign w_shift      = (r_state == ST_HIGH) && w_tick;
  assign w_last_bit   = (r_bit_cnt == BCW'(WIDTH - 1));
  assign w_enter_done = (w_state_nxt == ST_DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_SETUP;
      ST_SETUP: if (w_tick) w_state_nxt = ST_HIGH;
      ST_HIGH: begin
        if (w_tick) begin
          if (w_last_bit) w_state_nxt = r_mode ? ST_DONE : ST_LOAD;
          else            w_state_nxt = ST_SETUP;
        end
      end
      ST_LOAD:  if (w_tick && (r_load_cnt == LCW'(LOAD_CYCLES - 1))) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Pin strobes are registered from the next state so they align with it.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_load_cnt   <= '0;
      r_mode       <= 1'b0;
      r_wrote_once <= 1'b0;
      r_clk_sr     <= 1'b0;
      r_load_sr    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_sr  <= (w_state_nxt == ST_HIGH);
      r_load_sr <= (w_state_nxt == ST_LOAD);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_mode     <= mode;
        r_bit_cnt  <= '0;
        r_load_cnt <= '0;
      end
      if (w_shift) r_bit_cnt <= r_bit_cnt + BCW'(1);
      if ((r_state == ST_LOAD) && w_tick) r_load_cnt <= r_load_cnt + LCW'(1);
      if (w_enter_done && !r_mode) r_wrote_once <= 1'b1;
    end
  end

  assign clk_sr  = r_clk_sr;
  assign load_sr = r_load_sr;
  assign busy    = r_busy;
  assign done    = r_done;

  for (genvar c = 0; c < NCH; c++) begin : g_chain
    localparam int unsigned LSB = chain_lsb(c, WIDTH);

    logic [WIDTH-1:0] r_tx, r_rx, r_wdata, r_last, r_dout;
    logic [WIDTH-1:0] w_din, w_first_src, w_tx_rot, w_rx_sh, w_rx_fin;
    logic             r_dbit, r_mis, w_first_bit, w_next_bit;

    assign w_din = din[LSB +: WIDTH];

    // tx rotates rather than shifts, so after a full op it again holds the
    // written word and a following read-only op recirculates chip contents.
    always_comb begin
      w_first_src = mode ? r_tx : w_din;
      if (SHIFT_DIRECTION) begin
        w_tx_rot    = {r_tx[WIDTH-2:0], r_tx[WIDTH-1]};
        w_rx_sh     = {r_rx[WIDTH-2:0], data_in[c]};
        w_first_bit = w_first_src[WIDTH-1];
        w_next_bit  = w_tx_rot[WIDTH-1];
      end else begin
        w_tx_rot    = {r_tx[0], r_tx[WIDTH-1:1]};
        w_rx_sh     = {data_in[c], r_rx[WIDTH-1:1]};
        w_first_bit = w_first_src[0];
        w_next_bit  = w_tx_rot[0];
      end
      w_rx_fin = (r_state == ST_HIGH) ? w_rx_sh : r_rx;
    end

    // Results are committed on entry to DONE so they are valid with done.
    always_ff @(posedge clk_in) begin
      if (rst) begin
        r_tx    <= '0;
        r_rx    <= '0;
        r_wdata <= '0;
        r_last  <= '0;
        r_dout  <= '0;
        r_dbit  <= 1'b0;
        r_mis   <= 1'b0;
      end else begin
        if (w_accept) begin
          if (!mode) begin
            r_tx    <= w_din;
            r_wdata <= w_din;
          end
          r_dbit <= w_first_bit;
        end
        if (w_shift) begin
          r_tx <= w_tx_rot;
          r_rx <= w_rx_sh;
          if (!w_last_bit) r_dbit <= w_next_bit;
        end
        if (w_enter_done) begin
          r_dout <= w_rx_fin;
          r_mis  <= r_wrote_once && (w_rx_fin != r_last);
          r_dbit <= 1'b0;
          if (!r_mode) r_last <= r_wdata;
          else         r_tx   <= w_rx_fin;
        end
      end
    end

    assign dout[LSB +: WIDTH] = r_dout;
    assign mismatch[c]        = r_mis;
    assign data_out[c]        = r_dbit;
  end

endmodule
